frame_hdr_insert: RTL

Stream-framing stage sitting directly downstream of the count/alignment stage in the channelizer output path. It consumes the aligned sample stream with its per-sample count and final-count flag. It produces an AXI-Stream with `tlast` on the final sample of each frame and, when compiled in, a single header word in front of each frame. It also checks count continuity and flags sequence errors.

---
 rtl/frame_hdr_insert_pkg.sv | 27 ++
 rtl/frame_hdr_insert_axis_out_reg.sv | 56 +++++
 rtl/frame_hdr_insert.sv | 126 ++++++++++++
 3 files changed

// File: rtl/frame_hdr_insert_pkg.sv
// Shared definitions for the frame header insertion stage: FSM state
// encoding, header field offsets and the per-sample count width.
package frame_hdr_insert_pkg;

   localparam int CNT_WIDTH = 16;
   localparam int LEN_LSB   = 0;
   localparam int SEQ_LSB   = 16;

   // S_HDR: a new frame is about to start (header pending when enabled).
   // S_DATA: samples of the current frame pass straight through.
   typedef enum logic [0:0] {
      S_HDR  = 1'b0,
      S_DATA = 1'b1
   } state_e;

   // Header word: frame length (cnt_limit + 1, wrapping) in the low half,
   // frame sequence number in the high half.
   function automatic logic [31:0] make_hdr(input logic [CNT_WIDTH-1:0] limit,
                                            input logic [CNT_WIDTH-1:0] seq);
      logic [31:0] h;
      h = '0;
      h[LEN_LSB +: CNT_WIDTH] = limit + CNT_WIDTH'(1);
      h[SEQ_LSB +: CNT_WIDTH] = seq;
      return h;
   endfunction

endpackage

// File: rtl/frame_hdr_insert_axis_out_reg.sv
// axis_out_reg: single AXI-Stream output register. Holds its word while the
// consumer stalls and reports when a new word may be written.
module axis_out_reg #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_last,
   input  logic                  out_ready,
   output logic                  out_valid,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_last,
   output logic                  can_load
);

   logic                  valid_q, valid_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic                  last_q, last_d;

   // Register is free when empty or when its word leaves this cycle.
   assign can_load = !valid_q | out_ready;

   // Next-state for the output word: load new word, drain, or hold.
   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      last_d  = last_q;
      if (can_load) begin
         valid_d = load;
      end
      if (load) begin
         data_d = in_data;
         last_d = in_last;
      end
   end

   // Output register state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         last_q  <= 1'b0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
         last_q  <= last_d;
      end
   end

   assign out_valid = valid_q;
   assign out_data  = data_q;
   assign out_last  = last_q;

endmodule

// File: rtl/frame_hdr_insert.sv
// frame_hdr_insert: turns the aligned sample stream (count + final flag) into
// an AXI-Stream with tlast per frame, optionally prefixing each frame with a
// header word, and flags count discontinuities (sticky seq_err).
// Build option: define FRAME_HDR_EN to insert the header word; without it the
// S_HDR state is transparent and no header is emitted.
//
// Handshake: a word moves on either interface only in a cycle where both
// valid and ready are high; valid never depends on ready, and an offered
// output word (data/last) is held unchanged until it is taken.
module frame_hdr_insert
   import frame_hdr_insert_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  sync_reset,
   input  logic                  s_axis_tvalid,
   input  logic [DATA_WIDTH-1:0] s_axis_tdata,
   input  logic [CNT_WIDTH-1:0]  s_axis_count,
   input  logic                  s_axis_final_cnt,
   output logic                  s_axis_tready,
   input  logic [CNT_WIDTH-1:0]  cnt_limit,
   output logic                  m_axis_tvalid,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic                  m_axis_tlast,
   input  logic                  m_axis_tready,
   output logic [CNT_WIDTH-1:0]  frame_seq,
   output logic                  seq_err,
   output state_e                dbg_state
);

   state_e                state_q, state_d;
   logic [CNT_WIDTH-1:0]  frame_seq_q, frame_seq_d;
   logic [CNT_WIDTH-1:0]  exp_cnt_q, exp_cnt_d;
   logic                  seq_err_q, seq_err_d;

   logic                  can_load;
   logic                  hdr_mode;
   logic                  hdr_load;
   logic                  accept;
   logic                  reg_load;
   logic [DATA_WIDTH-1:0] hdr_word;
   logic [DATA_WIDTH-1:0] reg_data;
   logic                  reg_last;

`ifdef FRAME_HDR_EN
   assign hdr_mode = (state_q == S_HDR);
`else
   assign hdr_mode = 1'b0;
`endif

   // Input is held off during reset, while a header is pending, or while the
   // output register cannot take a word.
   assign s_axis_tready = !sync_reset & can_load & !hdr_mode;
   assign accept        = s_axis_tvalid & s_axis_tready;
   assign hdr_load      = hdr_mode & s_axis_tvalid & can_load;
   assign reg_load      = hdr_load | accept;

   // Header word built from the live cnt_limit and the current frame number.
   always_comb begin
      hdr_word       = '0;
      hdr_word[31:0] = make_hdr(cnt_limit, frame_seq_q);
   end

   assign reg_data = hdr_load ? hdr_word : s_axis_tdata;
   assign reg_last = hdr_load ? 1'b0 : s_axis_final_cnt;

   // FSM, frame numbering and count-continuity check.
   always_comb begin
      state_d     = state_q;
      frame_seq_d = frame_seq_q;
      exp_cnt_d   = exp_cnt_q;
      seq_err_d   = seq_err_q;
      if (hdr_load) begin
         state_d = S_DATA;
      end
      if (accept) begin
         if (s_axis_count != exp_cnt_q) begin
            seq_err_d = 1'b1;
         end
         if (s_axis_final_cnt) begin
            state_d     = S_HDR;
            frame_seq_d = frame_seq_q + CNT_WIDTH'(1);
            exp_cnt_d   = '0;
         end else begin
            state_d   = S_DATA;
            exp_cnt_d = s_axis_count + CNT_WIDTH'(1);
         end
      end
   end

   // Control state registers.
   always_ff @(posedge clk or posedge sync_reset) begin
      if (sync_reset) begin
         state_q     <= S_HDR;
         frame_seq_q <= '0;
         exp_cnt_q   <= '0;
         seq_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         frame_seq_q <= frame_seq_d;
         exp_cnt_q   <= exp_cnt_d;
         seq_err_q   <= seq_err_d;
      end
   end

   axis_out_reg #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_out_reg (
      .clk       (clk),
      .rst       (sync_reset),
      .load      (reg_load),
      .in_data   (reg_data),
      .in_last   (reg_last),
      .out_ready (m_axis_tready),
      .out_valid (m_axis_tvalid),
      .out_data  (m_axis_tdata),
      .out_last  (m_axis_tlast),
      .can_load  (can_load)
   );

   assign frame_seq = frame_seq_q;
   assign seq_err   = seq_err_q;
   assign dbg_state = state_q;

endmodule
